// File: rtl/rect_label_stream.sv
// Single-pass connected-component labeller over a raster stream of binarised cells.
// Streams one scaled bounding rectangle per surviving label, then pulses o_done.
module rect_label_stream #(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 6,
    parameter int COORD_W  = 6,
    parameter int NUM_RECT = 8,
    parameter int ID_W     = 3,
    parameter int OUT_W    = 8,
    parameter int SCALE_SH = 2,
    parameter int X_OFF    = 28,
    parameter int Y_OFF    = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_smin,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_wb,
    output logic               o_rect_valid,
    input  logic               i_rect_ready,
    output logic [OUT_W-1:0]   o_rect_x1,
    output logic [OUT_W-1:0]   o_rect_y1,
    output logic [OUT_W-1:0]   o_rect_x2,
    output logic [OUT_W-1:0]   o_rect_y2,
    output logic [ID_W-1:0]    o_rect_id,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_overflow
);

    localparam int NSLOT = NUM_RECT - 1;
    localparam int XI_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1;

    typedef enum logic [1:0] {T_IDLE, T_LABEL, T_EMIT} top_t;
    typedef enum logic [1:0] {C_ACCEPT, C_CLASSIFY, C_UPDATE, C_MERGE} cell_t;
    typedef enum logic [2:0] {K_BLACK, K_NONE, K_UP, K_LEFT, K_BOTH} kind_t;

    top_t  top_q, top_d;
    cell_t cell_q, cell_d;
    kind_t kind_q, kind_d;

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [ID_W-1:0]    prev_q, prev_d;
    logic               wb_q, wb_d;
    logic [ID_W-1:0]    up_q, up_d, left_q, left_d;
    logic [ID_W-1:0]    lb_q [GRID_W];
    logic [ID_W-1:0]    lb_d [GRID_W];
    logic [ID_W-1:0]    stk_q [NSLOT];
    logic [ID_W-1:0]    stk_d [NSLOT];
    logic [ID_W-1:0]    sp_q, sp_d;
    logic [COORD_W-1:0] bx0_q [NUM_RECT];
    logic [COORD_W-1:0] bx0_d [NUM_RECT];
    logic [COORD_W-1:0] bx1_q [NUM_RECT];
    logic [COORD_W-1:0] bx1_d [NUM_RECT];
    logic [COORD_W-1:0] by0_q [NUM_RECT];
    logic [COORD_W-1:0] by0_d [NUM_RECT];
    logic [COORD_W-1:0] by1_q [NUM_RECT];
    logic [COORD_W-1:0] by1_d [NUM_RECT];
    logic [NUM_RECT-1:0] bval_q, bval_d;
    logic [ID_W:0]      scan_q, scan_d;
    logic [COORD_W-1:0] smin_q, smin_d;
    logic               rv_q, rv_d, done_q, done_d, ovf_q, ovf_d;
    logic [OUT_W-1:0]   rx1_q, rx1_d, ry1_q, ry1_d, rx2_q, rx2_d, ry2_q, ry2_d;
    logic [ID_W-1:0]    rid_q, rid_d;

    logic [XI_W-1:0]    xi;
    logic [ID_W-1:0]    cur_up, cur_left, lab, sp_top, sid;
    logic [COORD_W:0]   wid, hgt;
    logic               adv, clr_tab;

    function automatic logic [COORD_W-1:0] cmin(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COORD_W-1:0] cmax(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [OUT_W-1:0] scale(input logic [COORD_W-1:0] c, input logic inc,
                                               input logic [OUT_W-1:0] off);
        logic [OUT_W-1:0] v;
        v = OUT_W'(c) + OUT_W'(inc);
        return (v << SCALE_SH) + off;
    endfunction

    assign o_ready      = (top_q == T_LABEL) && (cell_q == C_ACCEPT);
    assign o_busy       = (top_q != T_IDLE);
    assign o_rect_valid = rv_q;
    assign o_rect_x1    = rx1_q;
    assign o_rect_y1    = ry1_q;
    assign o_rect_x2    = rx2_q;
    assign o_rect_y2    = ry2_q;
    assign o_rect_id    = rid_q;
    assign o_done       = done_q;
    assign o_overflow   = ovf_q;

    always_comb begin
        top_d   = top_q;
        cell_d  = cell_q;
        kind_d  = kind_q;
        x_d     = x_q;
        y_d     = y_q;
        prev_d  = prev_q;
        wb_d    = wb_q;
        up_d    = up_q;
        left_d  = left_q;
        lb_d    = lb_q;
        stk_d   = stk_q;
        sp_d    = sp_q;
        bx0_d   = bx0_q;
        bx1_d   = bx1_q;
        by0_d   = by0_q;
        by1_d   = by1_q;
        bval_d  = bval_q;
        scan_d  = scan_q;
        smin_d  = smin_q;
        rv_d    = rv_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        rx1_d   = rx1_q;
        ry1_d   = ry1_q;
        rx2_d   = rx2_q;
        ry2_d   = ry2_q;
        rid_d   = rid_q;
        xi      = x_q[XI_W-1:0];
        cur_up  = lb_q[x_q[XI_W-1:0]];
        cur_left = (x_q == '0) ? '0 : prev_q;
        lab     = '0;
        sp_top  = sp_q - 1'b1;
        sid     = scan_q[ID_W-1:0];
        wid     = {1'b0, bx1_q[scan_q[ID_W-1:0]]} - {1'b0, bx0_q[scan_q[ID_W-1:0]]} + (COORD_W+1)'(1);
        hgt     = {1'b0, by1_q[scan_q[ID_W-1:0]]} - {1'b0, by0_q[scan_q[ID_W-1:0]]} + (COORD_W+1)'(1);
        adv     = 1'b0;
        clr_tab = 1'b0;

        case (top_q)
            T_LABEL: begin
                case (cell_q)
                    C_ACCEPT: begin
                        if (i_valid) begin
                            wb_d   = i_wb;
                            cell_d = C_CLASSIFY;
                        end
                    end
                    C_CLASSIFY: begin
                        up_d   = cur_up;
                        left_d = cur_left;
                        if (!wb_q)                                   kind_d = K_BLACK;
                        else if (cur_up == '0 && cur_left == '0)     kind_d = K_NONE;
                        else if (cur_left == '0 || cur_left == cur_up) kind_d = K_UP;
                        else if (cur_up == '0)                       kind_d = K_LEFT;
                        else                                         kind_d = K_BOTH;
                        cell_d = C_UPDATE;
                    end
                    C_UPDATE: begin
                        case (kind_q)
                            K_NONE: begin
                                if (sp_q == '0) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    lab         = stk_q[sp_top];
                                    sp_d        = sp_top;
                                    bx0_d[lab]  = x_q;
                                    bx1_d[lab]  = x_q;
                                    by0_d[lab]  = y_q;
                                    by1_d[lab]  = y_q;
                                    bval_d[lab] = 1'b1;
                                end
                            end
                            K_UP, K_LEFT: begin
                                lab        = (kind_q == K_UP) ? up_q : left_q;
                                bx0_d[lab] = cmin(bx0_q[lab], x_q);
                                bx1_d[lab] = cmax(bx1_q[lab], x_q);
                                by0_d[lab] = cmin(by0_q[lab], y_q);
                                by1_d[lab] = cmax(by1_q[lab], y_q);
                            end
                            K_BOTH: begin
                                lab         = up_q;
                                bx0_d[up_q] = cmin(cmin(bx0_q[up_q], bx0_q[left_q]), x_q);
                                bx1_d[up_q] = cmax(cmax(bx1_q[up_q], bx1_q[left_q]), x_q);
                                by0_d[up_q] = cmin(cmin(by0_q[up_q], by0_q[left_q]), y_q);
                                by1_d[up_q] = cmax(cmax(by1_q[up_q], by1_q[left_q]), y_q);
                                stk_d[sp_q] = left_q;
                                sp_d        = sp_q + 1'b1;
                            end
                            default: lab = '0;
                        endcase
                        lb_d[xi] = lab;
                        prev_d   = lab;
                        if (kind_q == K_BOTH) cell_d = C_MERGE;
                        else                  adv    = 1'b1;
                    end
                    C_MERGE: begin
                        bx0_d[left_q]  = '0;
                        bx1_d[left_q]  = '0;
                        by0_d[left_q]  = '0;
                        by1_d[left_q]  = '0;
                        bval_d[left_q] = 1'b0;
                        for (int unsigned i = 0; i < GRID_W; i++) begin
                            if (lb_q[i] == left_q) lb_d[i] = up_q;
                        end
                        adv = 1'b1;
                    end
                    default: cell_d = C_ACCEPT;
                endcase

                if (adv) begin
                    cell_d = C_ACCEPT;
                    if (x_q == COORD_W'(GRID_W - 1)) begin
                        x_d = '0;
                        if (y_q == COORD_W'(GRID_H - 1)) begin
                            y_d    = '0;
                            top_d  = T_EMIT;
                            smin_d = i_smin;
                            scan_d = (ID_W+1)'(1);
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            T_EMIT: begin
                // A pending rectangle stalls the scan; acceptance and the next load share a cycle.
                if (!rv_q || i_rect_ready) begin
                    rv_d = 1'b0;
                    if (scan_q == (ID_W+1)'(NUM_RECT)) begin
                        top_d   = T_IDLE;
                        done_d  = 1'b1;
                        clr_tab = 1'b1;
                    end else begin
                        if (bval_q[sid] && wid >= {1'b0, smin_q} && hgt >= {1'b0, smin_q}) begin
                            rv_d  = 1'b1;
                            rid_d = sid;
                            rx1_d = scale(bx0_q[sid], 1'b0, OUT_W'(X_OFF));
                            ry1_d = scale(by0_q[sid], 1'b0, OUT_W'(Y_OFF));
                            rx2_d = scale(bx1_q[sid], 1'b1, OUT_W'(X_OFF));
                            ry2_d = scale(by1_q[sid], 1'b1, OUT_W'(Y_OFF));
                        end
                        scan_d = scan_q + 1'b1;
                    end
                end
            end
            default: top_d = T_IDLE;
        endcase

        if (i_frame_start) begin
            top_d   = T_LABEL;
            cell_d  = C_ACCEPT;
            x_d     = '0;
            y_d     = '0;
            prev_d  = '0;
            rv_d    = 1'b0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            clr_tab = 1'b1;
            for (int unsigned i = 0; i < GRID_W; i++) lb_d[i] = '0;
        end

        if (clr_tab) begin
            sp_d   = ID_W'(NSLOT);
            bval_d = '0;
            for (int unsigned i = 0; i < NSLOT; i++) stk_d[i] = ID_W'(NUM_RECT - 1 - i);
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                bx0_d[i] = '0;
                bx1_d[i] = '0;
                by0_d[i] = '0;
                by1_d[i] = '0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            top_q  <= T_IDLE;
            cell_q <= C_ACCEPT;
            kind_q <= K_BLACK;
            x_q    <= '0;
            y_q    <= '0;
            prev_q <= '0;
            wb_q   <= 1'b0;
            up_q   <= '0;
            left_q <= '0;
            sp_q   <= ID_W'(NSLOT);
            bval_q <= '0;
            scan_q <= '0;
            smin_q <= '0;
            rv_q   <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            rx1_q  <= '0;
            ry1_q  <= '0;
            rx2_q  <= '0;
            ry2_q  <= '0;
            rid_q  <= '0;
            for (int unsigned i = 0; i < GRID_W; i++) lb_q[i] <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) stk_q[i] <= ID_W'(NUM_RECT - 1 - i);
            for (int unsigned i = 0; i < NUM_RECT; i++) begin
                bx0_q[i] <= '0;
                bx1_q[i] <= '0;
                by0_q[i] <= '0;
                by1_q[i] <= '0;
            end
        end else begin
            top_q  <= top_d;
            cell_q <= cell_d;
            kind_q <= kind_d;
            x_q    <= x_d;
            y_q    <= y_d;
            prev_q <= prev_d;
            wb_q   <= wb_d;
            up_q   <= up_d;
            left_q <= left_d;
            lb_q   <= lb_d;
            stk_q  <= stk_d;
            sp_q   <= sp_d;
            bx0_q  <= bx0_d;
            bx1_q  <= bx1_d;
            by0_q  <= by0_d;
            by1_q  <= by1_d;
            bval_q <= bval_d;
            scan_q <= scan_d;
            smin_q <= smin_d;
            rv_q   <= rv_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            rx1_q  <= rx1_d;
            ry1_q  <= ry1_d;
            rx2_q  <= rx2_d;
            ry2_q  <= ry2_d;
            rid_q  <= rid_d;
        end
    end

endmodule

// File: tb/tb_rect_label_stream.sv
// Scoreboard bench: a frame-level labelling model queues expected rectangles,
// and a monitor pops and compares each rectangle the DUT hands over.
module tb_rect_label_stream;

    localparam int GW = 8, GH = 6, CW = 6, NR = 8, IW = 3, OW = 8;
    localparam int SH = 2, XO = 28, YO = 0;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          i_frame_start = 1'b0;
    logic [CW-1:0] i_smin = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_wb = 1'b0;
    logic          o_rect_valid;
    logic          i_rect_ready = 1'b0;
    logic [OW-1:0] o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2;
    logic [IW-1:0] o_rect_id;
    logic          o_done, o_busy, o_overflow;

    rect_label_stream #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .NUM_RECT(NR), .ID_W(IW),
        .OUT_W(OW), .SCALE_SH(SH), .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_frame_start(i_frame_start),
        .i_smin(i_smin), .i_valid(i_valid), .o_ready(o_ready), .i_wb(i_wb),
        .o_rect_valid(o_rect_valid), .i_rect_ready(i_rect_ready),
        .o_rect_x1(o_rect_x1), .o_rect_y1(o_rect_y1), .o_rect_x2(o_rect_x2),
        .o_rect_y2(o_rect_y2), .o_rect_id(o_rect_id), .o_done(o_done),
        .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int id; int x1; int y1; int x2; int y2; } rect_t;
    rect_t  exp_q[$];
    int     checks = 0, errors = 0;
    int     done_cnt = 0, rect_cnt = 0;
    int     rdy_mode = 0;
    bit     img [GH][GW];
    bit     hold_v = 1'b0;
    longint hold_val = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Labels frame img exactly as the stream would see it, then lists surviving rectangles.
    function automatic void model_frame(input int smin, output bit ovf, output int n);
        int lb[GW];
        int x0[NR], x1[NR], y0[NR], y1[NR];
        bit live[NR];
        int stk[$];
        int prev, up, left, lab;
        rect_t r;
        ovf = 1'b0;
        n = 0;
        prev = 0;
        for (int i = 0; i < GW; i++) lb[i] = 0;
        for (int i = 0; i < NR; i++) begin
            live[i] = 1'b0; x0[i] = 0; x1[i] = 0; y0[i] = 0; y1[i] = 0;
        end
        for (int i = NR - 1; i >= 1; i--) stk.push_back(i);
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                lab = 0;
                if (img[y][x]) begin
                    up = lb[x];
                    left = (x == 0) ? 0 : prev;
                    if (up == 0 && left == 0) begin
                        if (stk.size() == 0) ovf = 1'b1;
                        else begin
                            lab = stk.pop_back();
                            live[lab] = 1'b1;
                            x0[lab] = x; x1[lab] = x; y0[lab] = y; y1[lab] = y;
                        end
                    end else if (up != 0 && left != 0 && up != left) begin
                        lab = up;
                        if (x0[left] < x0[lab]) x0[lab] = x0[left];
                        if (x1[left] > x1[lab]) x1[lab] = x1[left];
                        if (y0[left] < y0[lab]) y0[lab] = y0[left];
                        if (y1[left] > y1[lab]) y1[lab] = y1[left];
                        live[left] = 1'b0;
                        stk.push_back(left);
                        for (int i = 0; i < GW; i++) if (lb[i] == left) lb[i] = up;
                    end else begin
                        lab = (up != 0) ? up : left;
                    end
                    if (lab != 0) begin
                        if (x < x0[lab]) x0[lab] = x;
                        if (x > x1[lab]) x1[lab] = x;
                        if (y < y0[lab]) y0[lab] = y;
                        if (y > y1[lab]) y1[lab] = y;
                    end
                end
                lb[x] = lab;
                prev = lab;
            end
        end
        for (int id = 1; id < NR; id++) begin
            if (live[id] && (x1[id] - x0[id] + 1) >= smin && (y1[id] - y0[id] + 1) >= smin) begin
                r.id = id;
                r.x1 = (x0[id] * (1 << SH) + XO) % 256;
                r.y1 = (y0[id] * (1 << SH) + YO) % 256;
                r.x2 = ((x1[id] + 1) * (1 << SH) + XO) % 256;
                r.y2 = ((y1[id] + 1) * (1 << SH) + YO) % 256;
                exp_q.push_back(r);
                n++;
            end
        end
    endfunction

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0:       i_rect_ready = 1'b1;
            1:       i_rect_ready = 1'($urandom_range(0, 1));
            default: i_rect_ready = 1'b0;
        endcase
    end

    always @(negedge sys_clk) begin
        rect_t e;
        longint cur;
        if (sys_rst_n) begin
            cur = longint'({o_rect_id, o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2});
            if (o_rect_valid) begin
                if (hold_v) check("hold_stable", cur, hold_val);
                if (i_rect_ready) begin
                    hold_v = 1'b0;
                    rect_cnt++;
                    if (exp_q.size() == 0) check("rect_expected", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("rect_id", o_rect_id, e.id);
                        check("rect_x1", o_rect_x1, e.x1);
                        check("rect_y1", o_rect_y1, e.y1);
                        check("rect_x2", o_rect_x2, e.x2);
                        check("rect_y2", o_rect_y2, e.y2);
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_val = cur;
                end
            end else if (hold_v) begin
                check("valid_held", o_rect_valid, 1);
                hold_v = 1'b0;
            end
            if (o_done) begin
                done_cnt++;
                check("done_drained", exp_q.size(), 0);
            end
        end
    end

    task automatic pulse_start();
        @(posedge sys_clk); #1 i_frame_start = 1'b1;
        @(posedge sys_clk); #1 i_frame_start = 1'b0;
    endtask

    task automatic send_cell(input bit wb);
        int k;
        i_valid = 1'b1;
        i_wb = wb;
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!o_ready && k < 50);
        if (!o_ready) check("ready_timeout", o_ready, 1);
        @(posedge sys_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic clear_img();
        for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) img[y][x] = 1'b0;
    endtask

    task automatic run_frame(input int smin, input int mode);
        bit ovf;
        int n, d0, r0, k;
        i_smin = CW'(smin);
        model_frame(smin, ovf, n);
        d0 = done_cnt;
        r0 = rect_cnt;
        rdy_mode = mode;
        pulse_start();
        check("busy_after_start", o_busy, 1);
        check("ovf_after_start", o_overflow, 0);
        for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) send_cell(img[y][x]);
        if (mode == 2) begin
            k = 0;
            while (!o_rect_valid && k < 200) begin @(negedge sys_clk); k++; end
            check("bp_rect_valid", o_rect_valid, 1);
            repeat (5) @(negedge sys_clk);
            rdy_mode = 0;
        end
        k = 0;
        while (done_cnt == d0 && k < 3000) begin @(negedge sys_clk); k++; end
        repeat (4) @(negedge sys_clk);
        check("done_once", done_cnt - d0, 1);
        check("rect_count", rect_cnt - r0, n);
        check("overflow_flag", o_overflow, ovf);
        check("busy_idle", o_busy, 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_ready", o_ready, 0);
        check("rst_rect_valid", o_rect_valid, 0);
        check("rst_rect_data", longint'({o_rect_id, o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2}), 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_overflow", o_overflow, 0);
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;

        clear_img();
        img[2][3] = 1'b1;
        run_frame(1, 0);

        clear_img();
        img[1][1] = 1'b1; img[1][3] = 1'b1;
        img[2][1] = 1'b1; img[2][2] = 1'b1; img[2][3] = 1'b1;
        run_frame(1, 0);

        clear_img();
        img[0][0] = 1'b1;
        img[3][4] = 1'b1; img[3][5] = 1'b1; img[4][4] = 1'b1; img[4][5] = 1'b1;
        run_frame(2, 0);

        clear_img();
        for (int x = 0; x < GW; x += 2) begin img[0][x] = 1'b1; img[2][x] = 1'b1; end
        run_frame(1, 0);
        repeat (5) @(negedge sys_clk);
        check("overflow_sticky", o_overflow, 1);

        clear_img();
        img[0][1] = 1'b1; img[1][1] = 1'b1;
        img[3][5] = 1'b1; img[4][6] = 1'b1; img[4][5] = 1'b1;
        run_frame(1, 2);

        pulse_start();
        check("abort_ovf_cleared", o_overflow, 0);
        for (int i = 0; i < 20; i++) send_cell(1'($urandom_range(0, 1)));
        clear_img();
        run_frame(1, 0);

        for (int f = 0; f < 10; f++) begin
            int p;
            p = $urandom_range(15, 60);
            for (int y = 0; y < GH; y++)
                for (int x = 0; x < GW; x++) img[y][x] = ($urandom_range(0, 99) < p);
            run_frame($urandom_range(0, 3), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_label_stream.md
Name: rect_label_stream

Overview:
- Parametrised successor to the fixed-size rectangle divider in the pre-processing chain.
- Consumes a raster-ordered stream of binarised (corroded) grid cells and performs single-pass connected-component labelling with label merge.
- Streams out one scaled bounding rectangle per surviving component over a valid/ready handshake, then pulses done.
- Sits between the corrosion stage and the letter/rect overlay writer.

Parameters:
GRID_W, 8, grid cells per row
GRID_H, 6, grid rows per frame
COORD_W, 6, cell-coordinate width; must satisfy 2^COORD_W >= max(GRID_W, GRID_H)
NUM_RECT, 8, label slots; ID 0 means "no label", so usable labels are 1..NUM_RECT-1
ID_W, 3, label width, clog2(NUM_RECT)
OUT_W, 8, output coordinate width
SCALE_SH, 2, output scale as a left shift
X_OFF, 28, output x offset
Y_OFF, 0, output y offset

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
i_frame_start  in  1  one-cycle pulse; clears all state and starts a new frame
i_smin  in  COORD_W  minimum component width and height, in cells
i_valid  in  1  cell valid
o_ready  out  1  cell accepted when i_valid && o_ready
i_wb  in  1  cell value; 1 = white (object)
o_rect_valid  out  1  rectangle output valid
i_rect_ready  in  1  downstream accepts rectangle
o_rect_x1, o_rect_y1, o_rect_x2, o_rect_y2  out  OUT_W each  scaled rectangle corners
o_rect_id  out  ID_W  label of the emitted rectangle
o_done  out  1  one-cycle pulse after the last rectangle of a frame
o_busy  out  1  high from i_frame_start until o_done
o_overflow  out  1  sticky; cleared by i_frame_start

Behaviour:
- Reset values: o_ready=0, o_rect_valid=0, all rect outputs 0, o_done=0, o_busy=0, o_overflow=0.
- Reset state: free stack holds 1..NUM_RECT-1 with 1 on top; bbox table and line buffer all 0; FSM IDLE.
- Top FSM: IDLE -> LABEL on i_frame_start; LABEL -> EMIT after cell (GRID_W-1, GRID_H-1) finishes processing; EMIT -> IDLE after ID NUM_RECT-1 is scanned; o_done pulses on that transition.
- i_frame_start in any state: abort, reinitialise stack/table/line buffer/counters, enter LABEL; clear o_rect_valid and o_overflow.
- LABEL, per-cell sub-FSM:
  - ACCEPT (o_ready=1) -> CLASSIFY -> UPDATE -> MERGE (BOTH case only) -> ACCEPT.
  - o_ready is low outside ACCEPT: 3 cycles per cell, 4 on merge.
- CLASSIFY:
  - up = line buffer entry for the current x.
  - left = previous cell's label; forced to 0 when x==0.
  - Black cell -> BLACK.
  - White cell: both 0 -> NONE; exactly one nonzero -> UP or LEFT; both nonzero and equal -> UP; both nonzero and unequal -> BOTH.
- UPDATE, by case:
  - NONE: pop stack; new bbox = (x,y,x,y).
  - NONE with stack empty: o_overflow=1 and the cell is treated as BLACK.
  - UP/LEFT: min/max-extend that label's bbox with (x,y).
  - BOTH: up bbox = union of up, left and (x,y); push left onto stack.
  - All cases: write the resulting label (0 for BLACK) into the line buffer at x.
- MERGE: clear left's bbox and valid flag; rewrite every line-buffer entry equal to left to up.
- Push and pop never occur in the same cycle.
- Raster counters: x wraps at GRID_W-1, and y increments on that wrap.
- EMIT: scan IDs 1..NUM_RECT-1 in ascending order, one ID per cycle while no rectangle is pending.
- A rectangle is emitted when the label is allocated and both (xmax-xmin+1) >= i_smin and (ymax-ymin+1) >= i_smin.
- Emitted coordinates, computed in OUT_W bits and truncated modulo 2^OUT_W:
  - x1 = (xmin<<SCALE_SH) + X_OFF
  - y1 = (ymin<<SCALE_SH) + Y_OFF
  - x2 = ((xmax+1)<<SCALE_SH) + X_OFF
  - y2 = ((ymax+1)<<SCALE_SH) + Y_OFF
- Output handshake: o_rect_valid is held with stable data until i_rect_ready; the scan stalls meanwhile. Zero-bubble back-to-back transfer is allowed.
- End of EMIT: free stack reset to 1..NUM_RECT-1, table cleared.
- i_smin is sampled at EMIT entry.

Test Plan:
- Single white cell at (3,2) in an otherwise black 8x6 frame, i_smin=1 -> one rect: id=1, x1=40, y1=8, x2=44, y2=12; then o_done.
- U-shape: whites at (1,1),(3,1),(1,2),(2,2),(3,2) -> MERGE at (3,2) (up=2, left=1); exactly one rect: id=2, x1=32, y1=4, x2=44, y2=12.
- Size filter: 1x1 blob at (0,0) and 2x2 blob at (4,3..4), i_smin=2 -> only the 2x2 blob emitted: x1=44, y1=12, x2=52, y2=20.
- Overflow: NUM_RECT=4, five isolated white cells in row 0 -> three rects (ids 1..3); o_overflow=1 until the next i_frame_start.
- Backpressure: two blobs, i_rect_ready low for 5 cycles while the first rect is valid -> data stable, no loss, second rect follows, o_done once.
- Abort: i_frame_start after 20 cells, then an all-black frame -> no rect, o_done after the scan, o_overflow=0.
